uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter for the user project. It is the sending end of the serial link that the `tbuart` bench monitor receives. Firmware or the TMS1x00 core pushes bytes through a valid/ready port into a small FIFO. The block serialises them LSB-first on `tx` at a runtime-programmable bit period, so test progress and debug text can be streamed out of the user area without the management core's UART.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_buffered.sv | 137 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and frame constants.
// No logic; no latency or backpressure.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small power-of-2 byte FIFO with wrap-bit pointers and a registered full flag.
// Latency: a push is visible at dout one edge later; backpressure: push ignored while full, pop ignored while empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      wr_ptr_d, rd_ptr_d;
    logic             full_q;
    logic             push_acc, pop_acc;

    assign push_acc = push && !full_q;
    assign pop_acc  = pop && !empty;

    assign wr_ptr_d = push_acc ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = pop_acc  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = full_q;
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // Full from the next pointers so the flag is a flop, not a pop-dependent path.
            full_q   <= (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        end
    end

    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed, LSB-first, runtime bit period of divisor+1 clocks.
// Latency: tx falls one edge after a push into an idle block; backpressure: ready_out drops while the FIFO is full.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [DIV_W-1:0] divisor,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx,
    output logic             busy
);

    uart_tx_state_t   state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             pop, bit_end;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clock  (clock),
        .resetb (resetb),
        .push   (valid_in),
        .pop    (pop),
        .din    (data_in),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign ready_out = !fifo_full;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign bit_end   = (baud_q == '0);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        div_d     = div_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    div_d   = divisor;
                    baud_d  = divisor;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    baud_d    = div_q;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    baud_d    = div_q;
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit so frames are contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        div_d   = divisor;
                        baud_d  = divisor;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        // Entering IDLE implies the FIFO is empty now, so only a same-edge push keeps busy high.
        busy_d = (state_d != IDLE) || (valid_in && ready_out);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            div_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: scoreboard of expected frames checked by a cycle-level line receiver.
module tb_uart_tx_buffered;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clock;
    logic             resetb;
    logic [DIV_W-1:0] divisor;
    logic [7:0]       data_in;
    logic             valid_in;
    logic             ready_out;
    logic             tx;
    logic             busy;

    uart_tx_buffered #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clock     (clock),
        .resetb    (resetb),
        .divisor   (divisor),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx        (tx),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t       exp_q[$];
    int         start_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc_n   = 0;

    exp_t       cur;
    bit         rx_active = 0;
    int         rx_bit = 0;
    int         rx_cyc = 0;
    int         rx_errs = 0;
    int         rx_done = 0;
    logic [7:0] rx_byte = '0;
    logic       lvl;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc_n++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line receiver: each level of every frame must hold for exactly div+1 cycles.
    always @(negedge clock) begin
        if (!resetb) begin
            rx_active = 0;
        end else begin
            if (!rx_active && tx === 1'b0) begin
                chk("rx_expected_start", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur       = exp_q.pop_front();
                    rx_active = 1;
                    rx_bit    = 0;
                    rx_cyc    = 0;
                    rx_errs   = 0;
                    rx_byte   = '0;
                    start_q.push_back(cyc_n);
                end
            end
            if (rx_active) begin
                lvl = (rx_bit == 0) ? 1'b0 : (rx_bit == 9) ? 1'b1 : cur.data[rx_bit-1];
                if (tx !== lvl) rx_errs++;
                if (rx_bit >= 1 && rx_bit <= 8 && rx_cyc == cur.div / 2) rx_byte[rx_bit-1] = tx;
                rx_cyc++;
                if (rx_cyc == cur.div + 1) begin
                    rx_cyc = 0;
                    rx_bit++;
                    if (rx_bit == 10) begin
                        chk("rx_level_errors", rx_errs, 0);
                        chk("rx_byte", rx_byte, cur.data);
                        rx_active = 0;
                        rx_done++;
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input int d, output int waited);
        logic acc;
        waited   = 0;
        acc      = 1'b0;
        valid_in = 1'b1;
        data_in  = b;
        while (!acc && waited < 2000) begin
            acc = ready_out;
            @(posedge clock);
            #1;
            waited++;
        end
        valid_in = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
        else exp_q.push_back('{data: b, div: d});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_active || busy) && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, n < 5000, 1);
    endtask

    initial begin
        int w;
        int base;
        int lows;
        int n;
        resetb   = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        divisor  = 16'd3;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready_out, 1);
        chk("reset_busy", busy, 0);
        resetb = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Single frame at 4 clocks per bit
        push_byte(8'h55, 3, w);
        chk("t1_tx_before_pop", tx, 1);
        @(posedge clock); #1;
        chk("t1_tx_start", tx, 0);
        repeat (39) @(posedge clock);
        #1;
        chk("t1_busy_39", busy, 1);
        @(posedge clock); #1;
        chk("t1_busy_40", busy, 0);
        chk("t1_tx_idle", tx, 1);
        wait_idle("t1_idle");

        // Back-to-back frames at 1 clock per bit
        divisor = 16'd0;
        start_q.delete();
        push_byte(8'hA3, 0, w);
        push_byte(8'h00, 0, w);
        push_byte(8'hFF, 0, w);
        wait_idle("t2_idle");
        chk("t2_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("t2_gap1", start_q[1] - start_q[0], 10);
            chk("t2_gap2", start_q[2] - start_q[1], 10);
        end

        // Full FIFO backpressure
        divisor = 16'd9;
        push_byte(8'h3C, 9, w);
        repeat (3) @(posedge clock);
        #1;
        push_byte(8'h01, 9, w);
        push_byte(8'h02, 9, w);
        push_byte(8'h03, 9, w);
        push_byte(8'h04, 9, w);
        chk("t3_ready_low", ready_out, 0);
        base = rx_done;
        push_byte(8'h05, 9, w);
        chk("t3_fifth_after_pop", rx_done, base + 1);
        chk("t3_fifth_waited", w > 50, 1);
        wait_idle("t3_idle");

        // Divisor change mid-frame takes effect on the next frame
        divisor = 16'd3;
        start_q.delete();
        push_byte(8'hC6, 3, w);
        push_byte(8'h9B, 7, w);
        repeat (10) @(posedge clock);
        #1;
        divisor = 16'd7;
        wait_idle("t4_idle");
        if (start_q.size() == 2) chk("t4_gap", start_q[1] - start_q[0], 40);
        else chk("t4_frames", start_q.size(), 2);

        // Reset mid-frame during data bit 4 of 0x0F
        divisor = 16'd3;
        push_byte(8'h0F, 3, w);
        push_byte(8'h11, 3, w);
        push_byte(8'h22, 3, w);
        n = 0;
        while (!(rx_active && rx_bit == 5) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("t5_reach_bit4", n < 500, 1);
        chk("t5_tx_low_bit4", tx, 0);
        resetb = 1'b0;
        #1;
        chk("t5_tx_reset", tx, 1);
        chk("t5_busy_reset", busy, 0);
        chk("t5_ready_reset", ready_out, 1);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        resetb = 1'b1;
        lows = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("t5_quiet_after_reset", lows, 0);
        base = rx_done;
        push_byte(8'h5A, 3, w);
        wait_idle("t5_idle");
        chk("t5_new_frame", rx_done, base + 1);

        // Pointer wrap-around with random gaps
        divisor = 16'd1;
        base = rx_done;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            push_byte(8'($urandom_range(0, 255)), 1, w);
        end
        wait_idle("t6_idle");
        chk("t6_count", rx_done - base, 2 * DEPTH + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
